control_sincronizacion_rx: RTL and testbench



---
 rtl/sincronizacion_defs.sv | 22 ++
 rtl/contador_saturado.sv | 35 +++
 rtl/control_sincronizacion_rx.sv | 125 ++++++++++++
 tb/tb_control_sincronizacion_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sincronizacion_defs.sv
// Shared constants for the receive-side link controller: state encodings,
// training/idle characters and default sizing.
package sincronizacion_defs;

    localparam logic [2:0] DESCONECTADO  = 3'd0;
    localparam logic [2:0] ESPERA        = 3'd1;
    localparam logic [2:0] ENTRENAMIENTO = 3'd2;
    localparam logic [2:0] ENLACE        = 3'd3;
    localparam logic [2:0] ERROR_REC     = 3'd4;

    localparam logic [7:0] COM_CHAR = 8'hBC;
    localparam logic [7:0] IDL_CHAR = 8'h7C;

    localparam int unsigned N_TRAIN_DEF = 4;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned ERR_W_DEF   = 4;

    // Counter widths sized for the legal ranges N_TRAIN<=15 and TIMEOUT<=255.
    localparam int unsigned COM_CNT_W = 4;
    localparam int unsigned TMO_CNT_W = 8;

endpackage

// File: rtl/contador_saturado.sv
// Up-counter with synchronous clear and saturation at all-ones.
// Clear has priority over increment; reset has priority over both.
module contador_saturado #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cuenta
);

    logic [WIDTH-1:0] cuenta_q;
    logic [WIDTH-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr) begin
            cuenta_d = '0;
        end else if (inc && !(&cuenta_q)) begin
            cuenta_d = cuenta_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/control_sincronizacion_rx.sv
// Receive link controller after the deserializer: trains on COM characters,
// declares link up, forwards payload bytes and requests realignment on loss.
module control_sincronizacion_rx
    import sincronizacion_defs::*;
#(
    parameter int unsigned N_TRAIN = N_TRAIN_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter logic [7:0]  COM     = COM_CHAR,
    parameter logic [7:0]  IDL     = IDL_CHAR,
    parameter int unsigned ERR_W   = ERR_W_DEF
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             active_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             link_up,
    output logic             resync,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       estado
);

    logic [2:0]           estado_q, estado_d;
    logic [7:0]           data_q;
    logic                 valid_q, link_q, resync_q;
    logic [COM_CNT_W-1:0] com_cnt;
    logic [TMO_CNT_W-1:0] tmo_cnt;

    logic es_com, es_idl, entrada, entrenando, carga;
    logic com_clr, com_inc, tmo_clr, tmo_inc, err_inc;

    assign es_com     = (data_in == COM);
    assign es_idl     = (data_in == IDL);
    assign entrada    = (estado_q == ESPERA) && active_in;
    assign entrenando = (estado_q == ENTRENAMIENTO);

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            DESCONECTADO: estado_d = ESPERA;
            ESPERA: begin
                if (active_in) estado_d = ENTRENAMIENTO;
            end
            ENTRENAMIENTO: begin
                // Lock loss beats success, success beats timeout.
                if (!active_in) begin
                    estado_d = ESPERA;
                end else if (es_com && (com_cnt == COM_CNT_W'(N_TRAIN - 1))) begin
                    estado_d = ENLACE;
                end else if (tmo_cnt == TMO_CNT_W'(TIMEOUT - 1)) begin
                    estado_d = ERROR_REC;
                end
            end
            ENLACE: begin
                if (!active_in) estado_d = ERROR_REC;
            end
            ERROR_REC: estado_d = ESPERA;
            default:   estado_d = DESCONECTADO;
        endcase
    end

    // Training counters are cleared on entry so stale values never leak in.
    assign com_clr = entrada || (entrenando && !es_com);
    assign com_inc = entrenando && es_com;
    assign tmo_clr = entrada;
    assign tmo_inc = entrenando;
    // err_count steps with entry into ERROR_REC so it is visible alongside resync.
    assign err_inc = (estado_d == ERROR_REC);

    contador_saturado #(
        .WIDTH (COM_CNT_W)
    ) u_cnt_com (
        .clk    (clk_4f),
        .reset  (reset),
        .clr    (com_clr),
        .inc    (com_inc),
        .cuenta (com_cnt)
    );

    contador_saturado #(
        .WIDTH (TMO_CNT_W)
    ) u_cnt_tmo (
        .clk    (clk_4f),
        .reset  (reset),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .cuenta (tmo_cnt)
    );

    contador_saturado #(
        .WIDTH (ERR_W)
    ) u_cnt_err (
        .clk    (clk_4f),
        .reset  (reset),
        .clr    (1'b0),
        .inc    (err_inc),
        .cuenta (err_count)
    );

    assign carga = (estado_q == ENLACE) && active_in && !es_com && !es_idl;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            estado_q <= DESCONECTADO;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            link_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            valid_q  <= carga;
            link_q   <= (estado_d == ENLACE);
            resync_q <= (estado_d == ERROR_REC);
            if (carga) data_q <= data_in;
        end
    end

    assign estado    = estado_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign link_up   = link_q;
    assign resync    = resync_q;

endmodule

// File: tb/tb_control_sincronizacion_rx.sv
// Directed bench for control_sincronizacion_rx: training, payload forwarding,
// timeout, repeated lock loss with err_count saturation, and reset override.
module tb_control_sincronizacion_rx;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       active_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       link_up;
    logic       resync;
    logic [3:0] err_count;
    logic [2:0] estado;

    int n_total = 0;
    int n_pass  = 0;
    int err_esp = 0;

    always #5 clk_4f = ~clk_4f;

    control_sincronizacion_rx dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .active_in (active_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .link_up   (link_up),
        .resync    (resync),
        .err_count (err_count),
        .estado    (estado)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
    endtask

    // Drive one byte, let one edge sample it, then settle before checking.
    task automatic paso(input logic [7:0] d, input logic a);
        data_in   = d;
        active_in = a;
        @(posedge clk_4f);
        #1;
    endtask

    // From ESPERA with active_in=1: enter training, then 4 COM bytes.
    task automatic entrenar();
        paso(8'hBC, 1'b1);
        comprobar("entr_estado", 32'(estado), 2);
        for (int i = 0; i < 4; i++) paso(8'hBC, 1'b1);
        comprobar("entr_link", 32'(link_up), 1);
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = 8'h00;
        active_in = 1'b0;
        repeat (3) @(posedge clk_4f);
        #1;
        comprobar("rst_estado", 32'(estado), 0);
        comprobar("rst_data", 32'(data_out), 0);
        comprobar("rst_valid", 32'(valid_out), 0);
        comprobar("rst_link", 32'(link_up), 0);
        comprobar("rst_resync", 32'(resync), 0);
        comprobar("rst_err", 32'(err_count), 0);

        // Training from reset: 0 -> 1 -> 2, link after the 4th COM in training.
        reset = 1'b0;
        paso(8'hBC, 1'b1);
        comprobar("t1_estado_esp", 32'(estado), 1);
        paso(8'hBC, 1'b1);
        comprobar("t1_estado_ent", 32'(estado), 2);
        for (int i = 0; i < 3; i++) paso(8'hBC, 1'b1);
        comprobar("t1_link_3com", 32'(link_up), 0);
        paso(8'hBC, 1'b1);
        comprobar("t1_link_4com", 32'(link_up), 1);
        comprobar("t1_estado_enl", 32'(estado), 3);
        comprobar("t1_err", 32'(err_count), 0);

        // Payload filtering: IDL and COM suppressed, data_out held.
        paso(8'h7C, 1'b1);
        comprobar("p_idl_valid", 32'(valid_out), 0);
        comprobar("p_idl_data", 32'(data_out), 0);
        paso(8'h12, 1'b1);
        comprobar("p_12_valid", 32'(valid_out), 1);
        comprobar("p_12_data", 32'(data_out), 'h12);
        paso(8'hBC, 1'b1);
        comprobar("p_com_valid", 32'(valid_out), 0);
        comprobar("p_com_data", 32'(data_out), 'h12);
        paso(8'h34, 1'b1);
        comprobar("p_34_valid", 32'(valid_out), 1);
        comprobar("p_34_data", 32'(data_out), 'h34);

        // Lock loss in ENLACE: one ERROR_REC cycle, byte discarded.
        paso(8'h55, 1'b0);
        comprobar("d1_estado", 32'(estado), 4);
        comprobar("d1_resync", 32'(resync), 1);
        comprobar("d1_valid", 32'(valid_out), 0);
        comprobar("d1_link", 32'(link_up), 0);
        comprobar("d1_err", 32'(err_count), 1);
        paso(8'h00, 1'b1);
        comprobar("d1_estado_esp", 32'(estado), 1);
        comprobar("d1_resync_fin", 32'(resync), 0);

        // Non-COM byte restarts the run: BC,BC,00 then four BCs needed.
        paso(8'h00, 1'b1);
        comprobar("r_estado_ent", 32'(estado), 2);
        paso(8'hBC, 1'b1);
        paso(8'hBC, 1'b1);
        paso(8'h00, 1'b1);
        paso(8'hBC, 1'b1);
        paso(8'hBC, 1'b1);
        paso(8'hBC, 1'b1);
        comprobar("r_link_6", 32'(link_up), 0);
        comprobar("r_estado_6", 32'(estado), 2);
        paso(8'hBC, 1'b1);
        comprobar("r_link_7", 32'(link_up), 1);

        // Leave ENLACE, retrain, then run out the timeout with 16 zero bytes.
        paso(8'h00, 1'b0);
        comprobar("d2_err", 32'(err_count), 2);
        paso(8'h00, 1'b1);
        paso(8'h00, 1'b1);
        comprobar("to_estado_ent", 32'(estado), 2);
        for (int i = 0; i < 15; i++) paso(8'h00, 1'b1);
        comprobar("to_estado_15", 32'(estado), 2);
        comprobar("to_resync_15", 32'(resync), 0);
        paso(8'h00, 1'b1);
        comprobar("to_estado_16", 32'(estado), 4);
        comprobar("to_resync_16", 32'(resync), 1);
        comprobar("to_err", 32'(err_count), 3);
        paso(8'h00, 1'b1);
        comprobar("to_estado_esp", 32'(estado), 1);
        comprobar("to_resync_fin", 32'(resync), 0);

        // Lock loss during training beats success; no resync, no error.
        paso(8'hBC, 1'b1);
        for (int i = 0; i < 3; i++) paso(8'hBC, 1'b1);
        paso(8'hBC, 1'b0);
        comprobar("pri_estado", 32'(estado), 1);
        comprobar("pri_link", 32'(link_up), 0);
        comprobar("pri_resync", 32'(resync), 0);
        comprobar("pri_err", 32'(err_count), 3);

        // 20 lock drops through retraining; err_count saturates at 15.
        err_esp = 3;
        for (int k = 0; k < 20; k++) begin
            entrenar();
            paso(8'h56, 1'b1);
            comprobar("sat_valid_pl", 32'(valid_out), 1);
            paso(8'h78, 1'b0);
            err_esp = (err_esp < 15) ? err_esp + 1 : 15;
            comprobar("sat_resync", 32'(resync), 1);
            comprobar("sat_valid_drop", 32'(valid_out), 0);
            comprobar("sat_data_hold", 32'(data_out), 'h56);
            comprobar("sat_err", 32'(err_count), 32'(err_esp));
            paso(8'h00, 1'b1);
            comprobar("sat_resync_fin", 32'(resync), 0);
            comprobar("sat_estado_esp", 32'(estado), 1);
        end
        comprobar("sat_err_final", 32'(err_count), 15);

        // Reset in ENLACE with payload and simultaneous lock drop.
        entrenar();
        paso(8'h9A, 1'b1);
        comprobar("rr_valid_pre", 32'(valid_out), 1);
        reset = 1'b1;
        paso(8'h9B, 1'b0);
        comprobar("rr_valid", 32'(valid_out), 0);
        comprobar("rr_data", 32'(data_out), 0);
        comprobar("rr_estado", 32'(estado), 0);
        comprobar("rr_resync", 32'(resync), 0);
        comprobar("rr_link", 32'(link_up), 0);
        comprobar("rr_err", 32'(err_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
